// File: rtl/aes_soc_pkg.sv
// Shared definitions for the AES SoC receive path: block width, scheduler
// defaults and the decrypt scheduler state encoding.
package aes_soc_pkg;

  localparam int BLOCK_W          = 128;
  localparam int DEF_START_CYCLES = 2;
  localparam int DEF_TIMEOUT      = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } sched_state_t;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/block_fifo.sv
// Synchronous FIFO of whole blocks with a show-ahead head word.
// Pointers carry one extra wrap bit so full and empty need no counter.
module block_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/aes_rx_decrypt_sched.sv
// Buffers ciphertext blocks from the SPI receiver and feeds them one at a
// time to the decrypt core, delivering plaintext over a valid/ready port.
module aes_rx_decrypt_sched
  import aes_soc_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int START_CYCLES = DEF_START_CYCLES,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BLOCK_W-1:0] rx_data,
  input  logic               rx_valid,
  output logic [BLOCK_W-1:0] dec_ciphertext,
  output logic               dec_start,
  input  logic [BLOCK_W-1:0] dec_plaintext,
  input  logic               dec_done,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               clear_err,
  output logic               err_overflow,
  output logic               err_timeout,
  output logic               busy,
  output logic [15:0]        blk_done_cnt,
  output sched_state_t       dbg_state
);

  // Output handshake: a block transfers on any rising clk edge where
  // out_valid and out_ready are both 1; out_valid/out_data hold until then.

  localparam int SW = cnt_width(START_CYCLES);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  sched_state_t       state;
  logic [SW-1:0]      start_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic               done_q;
  logic               done_rise;
  logic               tmo_fire;
  logic               ovf_set;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [BLOCK_W-1:0] fifo_head;

  assign fifo_push = rx_valid && !fifo_full;
  assign ovf_set   = rx_valid && fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
  assign done_rise = dec_done && !done_q;
  assign tmo_fire  = (state == ST_WAIT) && !done_rise && (tmo_cnt == TMO_LAST);
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign dbg_state = state;

  block_fifo #(
    .W     (BLOCK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (rx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Reset value of 1 means a done level left high across reset must be
  // seen low before it can produce a rising edge.
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b1;
    else       done_q <= dec_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      dec_start      <= 1'b0;
      dec_ciphertext <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      blk_done_cnt   <= '0;
      start_cnt      <= '0;
      tmo_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            dec_ciphertext <= fifo_head;
            dec_start      <= 1'b1;
            start_cnt      <= '0;
            state          <= ST_START;
          end
        end
        ST_START: begin
          if (start_cnt == START_LAST) begin
            dec_start <= 1'b0;
            tmo_cnt   <= '0;
            state     <= ST_WAIT;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (done_rise) begin
            out_data  <= dec_plaintext;
            out_valid <= 1'b1;
            state     <= ST_OUTPUT;
          end else if (tmo_fire) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid    <= 1'b0;
            blk_done_cnt <= blk_done_cnt + 16'd1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A new error in the same cycle as clear_err wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_overflow <= ovf_set  || (err_overflow && !clear_err);
      err_timeout  <= tmo_fire || (err_timeout  && !clear_err);
    end
  end

endmodule

// File: tb/tb_aes_rx_decrypt_sched.sv
// Directed bench for aes_rx_decrypt_sched with a behavioural decrypt core
// and an output scoreboard.
module tb_aes_rx_decrypt_sched;
  import aes_soc_pkg::*;

  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BAD  = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
  localparam logic [127:0] GOOD = 128'h600dcafe600dcafe600dcafe600dcafe;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] rx_data;
  logic         rx_valid;
  logic [127:0] dec_ciphertext;
  logic         dec_start;
  logic [127:0] dec_plaintext;
  logic         dec_done;
  logic [127:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         clear_err;
  logic         err_overflow;
  logic         err_timeout;
  logic         busy;
  logic [15:0]  blk_done_cnt;
  sched_state_t dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  // Decrypt model controls: 0 = done pulse after model_lat cycles,
  // 1 = never done, 2 = stale done level then a second rising edge.
  int           model_mode = 0;
  int           model_lat  = 3;
  logic         model_fixed_en = 1'b0;
  logic [127:0] model_fixed = '0;

  always #5 clk = ~clk;

  aes_rx_decrypt_sched dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .dec_ciphertext (dec_ciphertext),
    .dec_start      (dec_start),
    .dec_plaintext  (dec_plaintext),
    .dec_done       (dec_done),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .clear_err      (clear_err),
    .err_overflow   (err_overflow),
    .err_timeout    (err_timeout),
    .busy           (busy),
    .blk_done_cnt   (blk_done_cnt),
    .dbg_state      (dbg_state)
  );

  function automatic logic [127:0] xform(input logic [127:0] c);
    return {c[63:0], c[127:64]} ^ 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  endfunction

  function automatic logic [127:0] blk(input int i);
    return {4{32'hc0de0000 + 32'(i)}};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [127:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while ((busy || out_valid || exp_q.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    check("idle_reached", (busy || out_valid || exp_q.size() != 0), 1'b0);
  endtask

  // Decrypt core model
  initial begin
    logic [127:0] ct;
    dec_done      = 1'b0;
    dec_plaintext = '0;
    forever begin
      @(negedge clk);
      if (dec_start && !reset) begin
        ct = dec_ciphertext;
        case (model_mode)
          0: begin
            repeat (model_lat) @(negedge clk);
            dec_plaintext = model_fixed_en ? model_fixed : xform(ct);
            dec_done = 1'b1;
            @(negedge clk);
            dec_done = 1'b0;
          end
          2: begin
            dec_plaintext = BAD;
            dec_done = 1'b1;
            repeat (6) @(negedge clk);
            dec_done = 1'b0;
            repeat (3) @(negedge clk);
            dec_plaintext = GOOD;
            dec_done = 1'b1;
            @(negedge clk);
            dec_done = 1'b0;
          end
          default: repeat (2) @(negedge clk);
        endcase
      end
    end
  end

  // Scoreboard: every output handshake must match the head of exp_q.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", out_valid, 1'b0);
        else                   check("out_data_sb", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    logic [127:0] held;
    logic         moved;
    logic         seen_start;
    logic         seen_valid;

    reset = 1'b1; rx_data = '0; rx_valid = 1'b0;
    out_ready = 1'b1; clear_err = 1'b0;
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_dec_start", dec_start, 1'b0);
    check("rst_err_ovf", err_overflow, 1'b0);
    check("rst_err_tmo", err_timeout, 1'b0);
    check("rst_cnt", blk_done_cnt, 16'd0);
    check("rst_ct", dec_ciphertext, 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_state", dbg_state, ST_IDLE);
    reset = 1'b0;
    tick();
    check("rst_busy", busy, 1'b0);

    // Single block, fixed plaintext after 20 cycles
    model_fixed_en = 1'b1; model_fixed = PT1; model_lat = 20;
    exp_q.push_back(PT1);
    send(CT1);
    check("t1_start_lat1", dec_start, 1'b0);
    tick();
    check("t1_start_lat2", dec_start, 1'b1);
    check("t1_ct", dec_ciphertext, CT1);
    tick();
    check("t1_start_c2", dec_start, 1'b1);
    tick();
    check("t1_start_end", dec_start, 1'b0);
    check("t1_wait", dbg_state, ST_WAIT);
    check("t1_ct_stable", dec_ciphertext, CT1);
    repeat (18) tick();
    check("t1_no_valid_yet", out_valid, 1'b0);
    tick();
    check("t1_valid", out_valid, 1'b1);
    check("t1_out_data", out_data, PT1);
    tick();
    check("t1_valid_drop", out_valid, 1'b0);
    check("t1_cnt", blk_done_cnt, 16'd1);
    model_fixed_en = 1'b0;

    // Burst: A..E accepted, F dropped, G dropped while clear_err is high
    model_lat = 3;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(xform(blk(i)));
      send(blk(i));
    end
    check("t2_no_ovf_yet", err_overflow, 1'b0);
    send(blk(5));
    check("t2_ovf", err_overflow, 1'b1);
    clear_err = 1'b1;
    send(blk(6));
    clear_err = 1'b0;
    check("t2_ovf_set_wins", err_overflow, 1'b1);
    wait_idle(400);
    check("t2_cnt", blk_done_cnt, 16'd6);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t2_ovf_clear", err_overflow, 1'b0);

    // Backpressure for 50 cycles with a second block queued
    model_lat = 5;
    out_ready = 1'b0;
    exp_q.push_back(xform(blk(7)));
    exp_q.push_back(xform(blk(8)));
    send(blk(7));
    send(blk(8));
    for (int k = 0; k < 100 && !out_valid; k++) tick();
    check("t3_valid", out_valid, 1'b1);
    held = out_data;
    moved = 1'b0;
    seen_start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (out_data !== held || !out_valid) moved = 1'b1;
      if (dec_start) seen_start = 1'b1;
    end
    check("t3_data_stable", moved, 1'b0);
    check("t3_no_start", seen_start, 1'b0);
    check("t3_held_value", held, xform(blk(7)));
    out_ready = 1'b1;
    tick();
    check("t3_cnt", blk_done_cnt, 16'd7);
    check("t3_start_gap", dec_start, 1'b0);
    tick();
    check("t3_next_start", dec_start, 1'b1);
    check("t3_next_ct", dec_ciphertext, blk(8));
    wait_idle(200);
    check("t3_cnt2", blk_done_cnt, 16'd8);

    // Timeout: core never completes
    model_mode = 1;
    send(blk(9));
    tick();
    check("t4_start", dec_start, 1'b1);
    repeat (4097) tick();
    check("t4_tmo_not_yet", err_timeout, 1'b0);
    check("t4_still_wait", dbg_state, ST_WAIT);
    tick();
    check("t4_tmo", err_timeout, 1'b1);
    check("t4_idle", dbg_state, ST_IDLE);
    check("t4_cnt", blk_done_cnt, 16'd8);
    check("t4_busy", busy, 1'b0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("t4_tmo_clear", err_timeout, 1'b0);
    model_mode = 0;
    exp_q.push_back(xform(blk(10)));
    send(blk(10));
    wait_idle(200);
    check("t4_cnt_after", blk_done_cnt, 16'd9);

    // Stale done level on entry to WAIT
    model_mode = 2;
    exp_q.push_back(GOOD);
    send(blk(11));
    tick();
    check("t5_start", dec_start, 1'b1);
    repeat (6) tick();
    check("t5_stale_ignored", out_valid, 1'b0);
    repeat (3) tick();
    check("t5_low_gap", out_valid, 1'b0);
    tick();
    check("t5_valid", out_valid, 1'b1);
    check("t5_data", out_data, GOOD);
    wait_idle(100);
    check("t5_cnt", blk_done_cnt, 16'd10);
    model_mode = 0;

    // Reset during WAIT with a second block still queued
    model_lat = 30;
    send(blk(12));
    send(blk(13));
    check("t6_start", dec_start, 1'b1);
    repeat (8) tick();
    check("t6_in_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    tick();
    check("t6_rst_state", dbg_state, ST_IDLE);
    tick();
    reset = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_cnt", blk_done_cnt, 16'd0);
    check("t6_out_data", out_data, 128'd0);
    check("t6_ct", dec_ciphertext, 128'd0);
    seen_start = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (dec_start) seen_start = 1'b1;
      if (out_valid) seen_valid = 1'b1;
    end
    check("t6_no_start", seen_start, 1'b0);
    check("t6_no_valid", seen_valid, 1'b0);
    model_lat = 4;
    exp_q.push_back(xform(blk(14)));
    send(blk(14));
    wait_idle(200);
    check("t6_cnt_after", blk_done_cnt, 16'd1);
    check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
